// File: rtl/ccff_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ccff_pkg
// Description : Shared types and constants for the configuration-chain loader.
// Revision    : 1.0 - initial release
//==============================================================================
package ccff_pkg;

    localparam int BYTE_W = 8;

    localparam logic CMD_PROG = 1'b0;
    localparam logic CMD_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        READ = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ccff_bit_serdes.sv
`default_nettype none
//==============================================================================
// Module      : ccff_bit_serdes
// Description : Byte shift register with fill count; LSB-first serializer or
//               bit-0-upward deserializer.
// Revision    : 1.0 - initial release
//==============================================================================
module ccff_bit_serdes
    import ccff_pkg::*;
#(
    parameter int SC_W = $clog2(BYTE_W + 1)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              clr,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              shift_out,
    input  logic              shift_in,
    input  logic              in_bit,
    output logic [BYTE_W-1:0] data,
    output logic [SC_W-1:0]   count
);

    localparam logic [SC_W-1:0] c_full = SC_W'(BYTE_W);

    logic [BYTE_W-1:0] r_data;
    logic [SC_W-1:0]   r_count;

    // A load on the last outgoing bit replaces it, keeping the stream gapless.
    always_ff @(posedge CK) begin
        if (RST || clr) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_data  <= load_data;
            r_count <= c_full;
        end else if (shift_out && (r_count != '0)) begin
            r_data  <= r_data >> 1;
            r_count <= r_count - SC_W'(1);
        end else if (shift_in && (r_count != c_full)) begin
            r_data  <= r_data | ({{(BYTE_W-1){1'b0}}, in_bit} << r_count);
            r_count <= r_count + SC_W'(1);
        end
    end

    assign data  = r_data;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
//==============================================================================
// Module      : ccff_bitstream_loader
// Description : Byte-stream programming and non-destructive readback of a
//               configuration flip-flop chain.
// Revision    : 1.0 - initial release
//==============================================================================
module ccff_bitstream_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              cmd,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done
);

    localparam int               SC_W        = $clog2(BYTE_W + 1);
    localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);
    localparam logic [SC_W-1:0]  c_last_slot = SC_W'(BYTE_W - 1);
    localparam logic [SC_W-1:0]  c_one_bit   = SC_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_mdata;
    logic              r_mvalid;

    logic [BYTE_W-1:0] w_sd_data;
    logic [SC_W-1:0]   w_sd_count;
    logic              w_last_bit;
    logic              w_s_fire;
    logic              w_xfer;
    logic              w_sd_clr;
    logic [BYTE_W-1:0] w_assembled;

    assign w_last_bit  = (r_cnt == CNT_W'(1));
    assign w_s_fire    = s_valid && s_ready;
    // Capturing slot 7 or the final chain bit closes the byte this cycle.
    assign w_xfer      = (r_state == READ) && shift_en &&
                         ((w_sd_count == c_last_slot) || w_last_bit);
    assign w_assembled = w_sd_data | ({{(BYTE_W-1){1'b0}}, ccff_tail} << w_sd_count);
    assign w_sd_clr    = (r_state == IDLE) || w_xfer ||
                         ((r_state == PROG) && shift_en && w_last_bit);

    ccff_bit_serdes #(
        .SC_W (SC_W)
    ) u_serdes (
        .CK        (CK),
        .RST       (RST),
        .clr       (w_sd_clr),
        .load      (w_s_fire),
        .load_data (s_data),
        .shift_out ((r_state == PROG) && shift_en),
        .shift_in  ((r_state == READ) && shift_en),
        .in_bit    (ccff_tail),
        .data      (w_sd_data),
        .count     (w_sd_count)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = (cmd == CMD_READ) ? READ : PROG;
            PROG: if (shift_en && w_last_bit) w_next = FIN;
            READ: if ((r_cnt == '0) && (!r_mvalid || m_ready)) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        s_ready   = 1'b0;
        ccff_head = 1'b0;
        busy      = (r_state != IDLE);
        done      = (r_state == FIN);
        case (r_state)
            PROG: begin
                shift_en  = (w_sd_count != '0);
                s_ready   = (w_sd_count == '0) ||
                            ((w_sd_count == c_one_bit) && !w_last_bit);
                ccff_head = w_sd_data[0];
            end
            READ: begin
                // Recirculate so the chain is intact after CHAIN_LEN shifts.
                shift_en  = (r_cnt != '0) && !(r_mvalid && !m_ready);
                ccff_head = ccff_tail;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= c_chain_len;
        end else if (shift_en) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
        end else if (w_xfer) begin
            r_mvalid <= 1'b1;
            r_mdata  <= w_assembled;
        end else if (r_mvalid && m_ready) begin
            r_mvalid <= 1'b0;
        end
    end

    assign m_valid = r_mvalid;
    assign m_data  = r_mdata;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
//==============================================================================
// Module      : tb_ccff_bitstream_loader
// Description : Directed self-checking bench; three loaders (16/13/1-bit chains)
//               each drive a behavioural chain model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ccff_bitstream_loader;

    localparam int NI = 3;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic       rst      [NI];
    logic       start    [NI];
    logic       cmd      [NI];
    logic       s_valid  [NI];
    logic       s_ready  [NI];
    logic [7:0] s_data   [NI];
    logic       m_valid  [NI];
    logic       m_ready  [NI];
    logic [7:0] m_data   [NI];
    logic       head     [NI];
    logic       tail     [NI];
    logic       shift_en [NI];
    logic       busy     [NI];
    logic       done     [NI];
    logic [15:0] chain   [NI];
    logic        pre_req [NI];
    logic [15:0] pre_val [NI];

    // Tail is chain[0]; the head enters at bit N-1.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = (g == 0) ? 16 : (g == 1) ? 13 : 1;
        logic [15:0] w_nx;

        ccff_bitstream_loader #(.CHAIN_LEN(N)) u_dut (
            .CK        (CK),
            .RST       (rst[g]),
            .start     (start[g]),
            .cmd       (cmd[g]),
            .s_valid   (s_valid[g]),
            .s_ready   (s_ready[g]),
            .s_data    (s_data[g]),
            .m_valid   (m_valid[g]),
            .m_ready   (m_ready[g]),
            .m_data    (m_data[g]),
            .ccff_head (head[g]),
            .ccff_tail (tail[g]),
            .shift_en  (shift_en[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );

        assign tail[g] = chain[g][0];
        assign w_nx = ((chain[g] >> 1) & ~(16'd1 << (N - 1))) | ({15'd0, head[g]} << (N - 1));

        always @(posedge CK) begin
            if (pre_req[g]) chain[g] <= pre_val[g];
            else if (shift_en[g]) chain[g] <= w_nx;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int         res_acc [4];
    int         res_nacc, res_shift, res_run, res_done_cyc, res_mv, res_head0;
    int         res_timeout, res_nrb, res_stall_bad, res_stall_seen;
    logic [7:0] res_rb [4];

    function automatic logic [31:0] outs(input int i);
        return {18'd0, m_data[i], s_ready[i], m_valid[i], head[i], shift_en[i], busy[i], done[i]};
    endfunction

    task automatic preload(input int idx, input logic [15:0] v);
        @(posedge CK); #1;
        pre_val[idx] = v;
        pre_req[idx] = 1'b1;
        @(posedge CK); #1;
        pre_req[idx] = 1'b0;
    endtask

    // Cycle 0 carries start; s_valid stays high throughout with 0xEE past the supplied bytes.
    task automatic run_prog(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                            input int inject_at, input int abort_at);
        int cyc;
        int run;
        bit fin;
        cyc = 0; run = 0; fin = 1'b0;
        for (int k = 0; k < 4; k++) res_acc[k] = -1;
        res_nacc = 0; res_shift = 0; res_run = 0; res_done_cyc = -1; res_mv = 0; res_head0 = -1;
        @(posedge CK); #1;
        start[idx] = 1'b1; cmd[idx] = 1'b0; s_valid[idx] = 1'b0;
        @(posedge CK); #1;
        start[idx] = 1'b0;
        cyc = 1;
        while (!fin && cyc < 200) begin
            s_valid[idx] = 1'b1;
            s_data[idx]  = (res_nacc == 0) ? b0 : (res_nacc == 1) ? b1 : 8'hEE;
            start[idx]   = (cyc == inject_at);
            cmd[idx]     = (cyc == inject_at);
            #1;
            if (s_valid[idx] && s_ready[idx]) begin
                if (res_nacc < 4) res_acc[res_nacc] = cyc;
                res_nacc++;
            end
            if (shift_en[idx]) begin
                if (res_head0 < 0) res_head0 = (head[idx] === 1'b1) ? 1 : 0;
                res_shift++;
                run++;
                if (run > res_run) res_run = run;
            end else begin
                run = 0;
            end
            if (m_valid[idx]) res_mv++;
            if (done[idx]) begin
                res_done_cyc = cyc;
                fin = 1'b1;
            end else if (abort_at > 0 && res_shift == abort_at) begin
                fin = 1'b1;
            end else begin
                @(posedge CK); #1;
                cyc++;
            end
        end
        s_valid[idx] = 1'b0; start[idx] = 1'b0; cmd[idx] = 1'b0;
        res_timeout = fin ? 0 : 1;
    endtask

    // m_ready is held low for `stall` cycles starting at the first m_valid.
    task automatic run_read(input int idx, input int stall);
        int cyc;
        int first_mv;
        bit fin;
        logic [7:0] first_data;
        cyc = 0; first_mv = -1; fin = 1'b0; first_data = 8'h00;
        res_nrb = 0; res_shift = 0; res_stall_bad = 0; res_stall_seen = 0; res_done_cyc = -1;
        for (int k = 0; k < 4; k++) res_rb[k] = 8'hEE;
        @(posedge CK); #1;
        start[idx] = 1'b1; cmd[idx] = 1'b1; m_ready[idx] = 1'b1;
        @(posedge CK); #1;
        start[idx] = 1'b0; cmd[idx] = 1'b0;
        cyc = 1;
        while (!fin && cyc < 200) begin
            if (m_valid[idx] && first_mv < 0) begin
                first_mv   = cyc;
                first_data = m_data[idx];
            end
            m_ready[idx] = !(first_mv >= 0 && cyc < first_mv + stall);
            #1;
            if (!m_ready[idx]) begin
                res_stall_seen++;
                if (shift_en[idx] !== 1'b0 || m_data[idx] !== first_data) res_stall_bad++;
            end
            if (shift_en[idx]) res_shift++;
            if (m_valid[idx] && m_ready[idx]) begin
                if (res_nrb < 4) res_rb[res_nrb] = m_data[idx];
                res_nrb++;
            end
            if (done[idx]) begin
                res_done_cyc = cyc;
                fin = 1'b1;
            end else begin
                @(posedge CK); #1;
                cyc++;
            end
        end
        m_ready[idx] = 1'b1;
        res_timeout = fin ? 0 : 1;
    endtask

    task automatic check_idle_after(input int idx, input string tag);
        @(posedge CK); #2;
        check_eq({tag, "_busy_after_done"}, 32'(busy[idx]), 32'd0);
        check_eq({tag, "_done_single"}, 32'(done[idx]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; cmd[i] = 1'b0; s_valid[i] = 1'b0;
            s_data[i] = 8'h00; m_ready[i] = 1'b1; pre_req[i] = 1'b1; pre_val[i] = 16'h0000;
        end
        repeat (3) @(posedge CK);
        #1;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; pre_req[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < NI; i++) check_eq($sformatf("reset_outputs_%0d", i), outs(i), 32'd0);

        // 1: 16-bit program, back-to-back bytes
        run_prog(0, 8'hA5, 8'h3C, -1, 0);
        check_eq("t1_timeout", 32'(res_timeout), 32'd0);
        check_eq("t1_accept0_cycle", 32'(res_acc[0]), 32'd1);
        check_eq("t1_accept1_cycle", 32'(res_acc[1]), 32'd9);
        check_eq("t1_accept_count", 32'(res_nacc), 32'd2);
        check_eq("t1_shift_count", 32'(res_shift), 32'd16);
        check_eq("t1_shift_run", 32'(res_run), 32'd16);
        check_eq("t1_done_cycle", 32'(res_done_cyc), 32'd18);
        check_eq("t1_chain", 32'(chain[0]), 32'h3CA5);
        check_idle_after(0, "t1");

        // 2: 13-bit program and readback, with discarded high bits
        run_prog(1, 8'hFF, 8'h1F, -1, 0);
        check_eq("t2_timeout", 32'(res_timeout), 32'd0);
        check_eq("t2_shift_count", 32'(res_shift), 32'd13);
        check_eq("t2_accept_count", 32'(res_nacc), 32'd2);
        check_eq("t2_chain", 32'(chain[1] & 16'h1FFF), 32'h1FFF);
        run_read(1, 0);
        check_eq("t2_rd_timeout", 32'(res_timeout), 32'd0);
        check_eq("t2_rd_bytes", 32'(res_nrb), 32'd2);
        check_eq("t2_rd_byte0", 32'(res_rb[0]), 32'hFF);
        check_eq("t2_rd_byte1", 32'(res_rb[1]), 32'h1F);
        check_eq("t2_rd_shifts", 32'(res_shift), 32'd13);
        check_eq("t2_rd_chain", 32'(chain[1] & 16'h1FFF), 32'h1FFF);
        run_prog(1, 8'h00, 8'hE0, -1, 0);
        check_eq("t2b_chain", 32'(chain[1] & 16'h1FFF), 32'h0000);
        run_read(1, 0);
        check_eq("t2b_rd_byte0", 32'(res_rb[0]), 32'h00);
        check_eq("t2b_rd_byte1", 32'(res_rb[1]), 32'h00);

        // 3: readback with backpressure
        preload(0, 16'hC35A);
        run_read(0, 5);
        check_eq("t3_timeout", 32'(res_timeout), 32'd0);
        check_eq("t3_bytes", 32'(res_nrb), 32'd2);
        check_eq("t3_byte0", 32'(res_rb[0]), 32'h5A);
        check_eq("t3_byte1", 32'(res_rb[1]), 32'hC3);
        check_eq("t3_stall_cycles", 32'(res_stall_seen), 32'd5);
        check_eq("t3_stall_violations", 32'(res_stall_bad), 32'd0);
        check_eq("t3_shifts", 32'(res_shift), 32'd16);
        check_eq("t3_chain_restored", 32'(chain[0]), 32'hC35A);

        // 4: readback command during PROG is ignored
        run_prog(0, 8'h96, 8'h0F, 4, 0);
        check_eq("t4_timeout", 32'(res_timeout), 32'd0);
        check_eq("t4_shift_count", 32'(res_shift), 32'd16);
        check_eq("t4_mvalid_seen", 32'(res_mv), 32'd0);
        check_eq("t4_done_cycle", 32'(res_done_cyc), 32'd18);
        check_eq("t4_chain", 32'(chain[0]), 32'h0F96);
        check_idle_after(0, "t4");

        // 5: reset mid-program, then full reprogram
        run_prog(0, 8'h12, 8'h34, -1, 5);
        check_eq("t5_abort_shifts", 32'(res_shift), 32'd5);
        @(posedge CK); #1;
        rst[0] = 1'b1;
        @(posedge CK); #1;
        check_eq("t5_reset_outputs", outs(0), 32'd0);
        rst[0] = 1'b0;
        run_prog(0, 8'h12, 8'h34, -1, 0);
        check_eq("t5_timeout", 32'(res_timeout), 32'd0);
        check_eq("t5_shift_count", 32'(res_shift), 32'd16);
        check_eq("t5_done_cycle", 32'(res_done_cyc), 32'd18);
        check_eq("t5_chain", 32'(chain[0]), 32'h3412);

        // 6: single-flop chain
        run_prog(2, 8'h01, 8'h00, -1, 0);
        check_eq("t6_timeout", 32'(res_timeout), 32'd0);
        check_eq("t6_accept_count", 32'(res_nacc), 32'd1);
        check_eq("t6_shift_count", 32'(res_shift), 32'd1);
        check_eq("t6_head", 32'(res_head0), 32'd1);
        check_eq("t6_done_cycle", 32'(res_done_cyc), 32'd3);
        check_eq("t6_chain", 32'(chain[2][0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
